// File: rtl/ysyx_040750_axi_pkg.sv
// ysyx_040750_axi_pkg
//   Shared AXI constants for the write arbiter and the read crossbar:
//   bus widths, response codes, channel ids and the write-arbiter state
//   encoding (one-hot).
package ysyx_040750_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;
  localparam int AXI_LEN_W  = 8;
  localparam int AXI_SIZE_W = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W = 2;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  // Requester ids, shared by the write arbiter and the read crossbar.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Read-crossbar constants.
  localparam int RD_NUM_MASTERS = 2;
  localparam int RD_ID_W        = 4;
  localparam int RD_MAX_OUTSTD  = 1;

  // Write-arbiter phases, one-hot.
  typedef enum logic [6:0] {
    WR_IDLE   = 7'b000_0001,
    WR_CH0_AW = 7'b000_0010,
    WR_CH1_AW = 7'b000_0100,
    WR_CH0_W  = 7'b000_1000,
    WR_CH1_W  = 7'b001_0000,
    WR_CH0_B  = 7'b010_0000,
    WR_CH1_B  = 7'b100_0000
  } wr_state_e;

  function automatic logic other_ch(input logic ch);
    return ~ch;
  endfunction

endpackage

// File: rtl/ysyx_040750_rr_arb2.sv
// ysyx_040750_rr_arb2
//   Two-way arbiter. Grant is combinational from the request pair; the
//   priority pointer advances to the other channel whenever a grant is
//   taken, contested or not.
//   Macro YSYX_040750_WR_FIXED_PRIO_EN: ch0 always wins, no pointer state.
// Ports:
//   I_clk, I_rst    clock, synchronous active-high reset
//   I_req[1:0]      request per channel
//   I_take          grant is being consumed this cycle
//   O_gnt_vld       some channel requests
//   O_gnt_ch        granted channel id
//   O_prio_ch       channel that wins a tie
module ysyx_040750_rr_arb2
  import ysyx_040750_axi_pkg::*;
(
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [1:0] I_req,
  input  logic       I_take,
  output logic       O_gnt_vld,
  output logic       O_gnt_ch,
  output logic       O_prio_ch
);

  assign O_gnt_vld = |I_req;

`ifdef YSYX_040750_WR_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{I_clk, I_rst, I_take};
  assign O_prio_ch = CH0;
  assign O_gnt_ch  = I_req[0] ? CH0 : CH1;
`else
  logic prio_q;

  always_ff @(posedge I_clk) begin
    if (I_rst)       prio_q <= CH0;
    else if (I_take) prio_q <= other_ch(O_gnt_ch);
  end

  assign O_prio_ch = prio_q;
  // Tie goes to the pointer, otherwise whichever channel asks.
  assign O_gnt_ch  = (&I_req) ? prio_q : (I_req[1] ? CH1 : CH0);
`endif

endmodule

// File: rtl/ysyx_040750_axi_wr_arbiter.sv
// ysyx_040750_axi_wr_arbiter
//   Shares one AXI write port between two requesters. A whole transaction
//   (AW, every W beat, B) belongs to one requester; grant is decided in
//   IDLE and registered, so the bus sees AW one cycle after the request.
//   Within the owning phase handshakes pass straight through.
//   Macro YSYX_040750_WR_FIXED_PRIO_EN: contested grants always go to ch0
//   (default build: round-robin).
// Ports:
//   I_clk, I_rst                   clock, synchronous active-high reset
//   I_chN_aw*/O_chN_awready        requester N write address
//   I_chN_w*/O_chN_wready          requester N write data
//   O_chN_b*/I_chN_bready          requester N write response
//   O_axi_aw*/I_axi_awready        bus write address
//   O_axi_w*/I_axi_wready          bus write data
//   I_axi_b*/O_axi_bready          bus write response
module ysyx_040750_axi_wr_arbiter
  import ysyx_040750_axi_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst,
  // requester 0
  input  logic [31:0] I_ch0_awaddr,
  input  logic [7:0]  I_ch0_awlen,
  input  logic [2:0]  I_ch0_awsize,
  input  logic [1:0]  I_ch0_awburst,
  input  logic        I_ch0_awvalid,
  output logic        O_ch0_awready,
  input  logic [63:0] I_ch0_wdata,
  input  logic [7:0]  I_ch0_wstrb,
  input  logic        I_ch0_wlast,
  input  logic        I_ch0_wvalid,
  output logic        O_ch0_wready,
  output logic [1:0]  O_ch0_bresp,
  output logic        O_ch0_bvalid,
  input  logic        I_ch0_bready,
  // requester 1
  input  logic [31:0] I_ch1_awaddr,
  input  logic [7:0]  I_ch1_awlen,
  input  logic [2:0]  I_ch1_awsize,
  input  logic [1:0]  I_ch1_awburst,
  input  logic        I_ch1_awvalid,
  output logic        O_ch1_awready,
  input  logic [63:0] I_ch1_wdata,
  input  logic [7:0]  I_ch1_wstrb,
  input  logic        I_ch1_wlast,
  input  logic        I_ch1_wvalid,
  output logic        O_ch1_wready,
  output logic [1:0]  O_ch1_bresp,
  output logic        O_ch1_bvalid,
  input  logic        I_ch1_bready,
  // shared bus
  output logic [31:0] O_axi_awaddr,
  output logic [7:0]  O_axi_awlen,
  output logic [2:0]  O_axi_awsize,
  output logic [1:0]  O_axi_awburst,
  output logic        O_axi_awvalid,
  input  logic        I_axi_awready,
  output logic [63:0] O_axi_wdata,
  output logic [7:0]  O_axi_wstrb,
  output logic        O_axi_wlast,
  output logic        O_axi_wvalid,
  input  logic        I_axi_wready,
  input  logic [1:0]  I_axi_bresp,
  input  logic        I_axi_bvalid,
  output logic        O_axi_bready
);

  wr_state_e state_q, state_d;
  logic      gnt_vld, gnt_ch, prio_ch;
  logic      take;
  logic      aw_hs, w_last_hs, b_hs;

  assign take = (state_q == WR_IDLE) && gnt_vld;

  ysyx_040750_rr_arb2 u_arb (
    .I_clk     (I_clk),
    .I_rst     (I_rst),
    .I_req     ({I_ch1_awvalid, I_ch0_awvalid}),
    .I_take    (take),
    .O_gnt_vld (gnt_vld),
    .O_gnt_ch  (gnt_ch),
    .O_prio_ch (prio_ch)
  );

  logic unused_prio;
  assign unused_prio = prio_ch;

  // Bus outputs are zero outside their owning phase, so these are only
  // ever true in the matching state.
  assign aw_hs     = O_axi_awvalid & I_axi_awready;
  assign w_last_hs = O_axi_wvalid & I_axi_wready & O_axi_wlast;
  assign b_hs      = I_axi_bvalid & O_axi_bready;

  // state register
  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= WR_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:   if (gnt_vld) state_d = (gnt_ch == CH1) ? WR_CH1_AW : WR_CH0_AW;
      WR_CH0_AW: if (aw_hs)     state_d = WR_CH0_W;
      WR_CH1_AW: if (aw_hs)     state_d = WR_CH1_W;
      WR_CH0_W:  if (w_last_hs) state_d = WR_CH0_B;
      WR_CH1_W:  if (w_last_hs) state_d = WR_CH1_B;
      WR_CH0_B:  if (b_hs)      state_d = WR_IDLE;
      WR_CH1_B:  if (b_hs)      state_d = WR_IDLE;
      default:                  state_d = WR_IDLE;
    endcase
  end

  // outputs: route the owner's channel for the current phase only
  always_comb begin
    O_axi_awaddr  = '0;
    O_axi_awlen   = '0;
    O_axi_awsize  = '0;
    O_axi_awburst = '0;
    O_axi_awvalid = 1'b0;
    O_axi_wdata   = '0;
    O_axi_wstrb   = '0;
    O_axi_wlast   = 1'b0;
    O_axi_wvalid  = 1'b0;
    O_axi_bready  = 1'b0;
    O_ch0_awready = 1'b0;
    O_ch0_wready  = 1'b0;
    O_ch0_bvalid  = 1'b0;
    O_ch0_bresp   = AXI_RESP_OKAY;
    O_ch1_awready = 1'b0;
    O_ch1_wready  = 1'b0;
    O_ch1_bvalid  = 1'b0;
    O_ch1_bresp   = AXI_RESP_OKAY;
    case (state_q)
      WR_CH0_AW: begin
        O_axi_awaddr  = I_ch0_awaddr;
        O_axi_awlen   = I_ch0_awlen;
        O_axi_awsize  = I_ch0_awsize;
        O_axi_awburst = I_ch0_awburst;
        O_axi_awvalid = I_ch0_awvalid;
        O_ch0_awready = I_axi_awready;
      end
      WR_CH1_AW: begin
        O_axi_awaddr  = I_ch1_awaddr;
        O_axi_awlen   = I_ch1_awlen;
        O_axi_awsize  = I_ch1_awsize;
        O_axi_awburst = I_ch1_awburst;
        O_axi_awvalid = I_ch1_awvalid;
        O_ch1_awready = I_axi_awready;
      end
      WR_CH0_W: begin
        O_axi_wdata   = I_ch0_wdata;
        O_axi_wstrb   = I_ch0_wstrb;
        O_axi_wlast   = I_ch0_wlast;
        O_axi_wvalid  = I_ch0_wvalid;
        O_ch0_wready  = I_axi_wready;
      end
      WR_CH1_W: begin
        O_axi_wdata   = I_ch1_wdata;
        O_axi_wstrb   = I_ch1_wstrb;
        O_axi_wlast   = I_ch1_wlast;
        O_axi_wvalid  = I_ch1_wvalid;
        O_ch1_wready  = I_axi_wready;
      end
      WR_CH0_B: begin
        O_ch0_bvalid  = I_axi_bvalid;
        O_ch0_bresp   = I_axi_bresp;
        O_axi_bready  = I_ch0_bready;
      end
      WR_CH1_B: begin
        O_ch1_bvalid  = I_axi_bvalid;
        O_ch1_bresp   = I_axi_bresp;
        O_axi_bready  = I_ch1_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040750_axi_wr_arbiter.sv
module tb_ysyx_040750_axi_wr_arbiter;

  logic I_clk = 1'b0;
  logic I_rst;
  always #5 I_clk = ~I_clk;

  // requester side, index = channel
  logic [1:0]  awvalid, wvalid, wlast, bready;
  logic [31:0] awaddr  [2];
  logic [7:0]  awlen   [2];
  logic [2:0]  awsize  [2];
  logic [1:0]  awburst [2];
  logic [63:0] wdata   [2];
  logic [7:0]  wstrb   [2];
  logic [1:0]  awready, wready, bvalid;
  logic [1:0]  bresp   [2];

  // bus side
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;

  ysyx_040750_axi_wr_arbiter dut (
    .I_clk(I_clk), .I_rst(I_rst),
    .I_ch0_awaddr(awaddr[0]), .I_ch0_awlen(awlen[0]), .I_ch0_awsize(awsize[0]),
    .I_ch0_awburst(awburst[0]), .I_ch0_awvalid(awvalid[0]), .O_ch0_awready(awready[0]),
    .I_ch0_wdata(wdata[0]), .I_ch0_wstrb(wstrb[0]), .I_ch0_wlast(wlast[0]),
    .I_ch0_wvalid(wvalid[0]), .O_ch0_wready(wready[0]),
    .O_ch0_bresp(bresp[0]), .O_ch0_bvalid(bvalid[0]), .I_ch0_bready(bready[0]),
    .I_ch1_awaddr(awaddr[1]), .I_ch1_awlen(awlen[1]), .I_ch1_awsize(awsize[1]),
    .I_ch1_awburst(awburst[1]), .I_ch1_awvalid(awvalid[1]), .O_ch1_awready(awready[1]),
    .I_ch1_wdata(wdata[1]), .I_ch1_wstrb(wstrb[1]), .I_ch1_wlast(wlast[1]),
    .I_ch1_wvalid(wvalid[1]), .O_ch1_wready(wready[1]),
    .O_ch1_bresp(bresp[1]), .O_ch1_bvalid(bvalid[1]), .I_ch1_bready(bready[1]),
    .O_axi_awaddr(axi_awaddr), .O_axi_awlen(axi_awlen), .O_axi_awsize(axi_awsize),
    .O_axi_awburst(axi_awburst), .O_axi_awvalid(axi_awvalid), .I_axi_awready(axi_awready),
    .O_axi_wdata(axi_wdata), .O_axi_wstrb(axi_wstrb), .O_axi_wlast(axi_wlast),
    .O_axi_wvalid(axi_wvalid), .I_axi_wready(axi_wready),
    .I_axi_bresp(axi_bresp), .I_axi_bvalid(axi_bvalid), .O_axi_bready(axi_bready)
  );

  // every DUT output in one vector
  logic [130:0] dut_vec;
  assign dut_vec = {axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst,
                    axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
                    awready, wready, bvalid, bresp[1], bresp[0]};

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [130:0] act, input logic [130:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_clk);
    #1;
  endtask

  task automatic zero_inputs();
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
  endtask

  task automatic do_reset();
    zero_inputs();
    I_rst = 1'b1;
    cyc(); cyc();
    I_rst = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: -1 when the port is free, else the requester holding it.
  // phase: 0 address, 1 data, 2 response.
  int own, ph, ptr;

  function automatic logic [130:0] model_exp();
    logic [45:0] aw;
    logic [73:0] w;
    logic        br;
    logic [1:0]  ar, wr, bv, r0, r1;
    aw = '0; w = '0; br = 1'b0; ar = '0; wr = '0; bv = '0; r0 = '0; r1 = '0;
    if (own >= 0) begin
      if (ph == 0) begin
        aw = {awvalid[own], awaddr[own], awlen[own], awsize[own], awburst[own]};
        ar[own] = axi_awready;
      end else if (ph == 1) begin
        w = {wvalid[own], wdata[own], wstrb[own], wlast[own]};
        wr[own] = axi_wready;
      end else begin
        br = bready[own];
        bv[own] = axi_bvalid;
        if (own == 0) r0 = axi_bresp; else r1 = axi_bresp;
      end
    end
    return {aw, w, br, ar, wr, bv, r1, r0};
  endfunction

  task automatic model_step();
    if (I_rst) begin
      own = -1; ptr = 0;
    end else if (own < 0) begin
      if (awvalid != 2'b00) begin
`ifdef YSYX_040750_WR_FIXED_PRIO_EN
        own = awvalid[0] ? 0 : 1;
`else
        own = (awvalid == 2'b11) ? ptr : (awvalid[0] ? 0 : 1);
        ptr = 1 - own;
`endif
        ph = 0;
      end
    end else if (ph == 0) begin
      if (awvalid[own] && axi_awready) ph = 1;
    end else if (ph == 1) begin
      if (wvalid[own] && axi_wready && wlast[own]) ph = 2;
    end else begin
      if (axi_bvalid && bready[own]) own = -1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0] awv, wv, wl, br;   // requester inputs
    logic       awr, wr, bv;       // bus inputs
    logic [1:0] rsp;
    logic       e_awv, e_wv, e_br; // expected bus valids / bready
    logic [1:0] e_awr, e_wr, e_bv; // expected per-requester readies / bvalid
    logic       ch;                // channel whose payload should be on the bus
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [130:0] act, exp;
    logic [31:0]  r;
    int           c;

    I_rst = 1'b1;
    zero_inputs();
    awaddr[0] = 32'h8000_0000; awlen[0] = 8'd3; awsize[0] = 3'd3; awburst[0] = 2'd1;
    awaddr[1] = 32'h8000_1000; awlen[1] = 8'd0; awsize[1] = 3'd2; awburst[1] = 2'd1;
    wdata[0] = 64'h1111_2222_3333_4444; wstrb[0] = 8'hff;
    wdata[1] = 64'haaaa_bbbb_cccc_dddd; wstrb[1] = 8'h0f;

    //          awv    wv     wl     br     awr wr bv rsp   eaw ew ebr eawr   ewr    ebv   ch
    tbl[0]  = '{2'b11, 2'b00, 2'b00, 2'b00, 0,  0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
    tbl[1]  = '{2'b11, 2'b01, 2'b00, 2'b00, 1,  1, 0, 2'b00, 1, 0, 0, 2'b01, 2'b00, 2'b00, 0};
    tbl[2]  = '{2'b10, 2'b01, 2'b00, 2'b00, 0,  1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0};
    tbl[3]  = '{2'b10, 2'b01, 2'b00, 2'b00, 0,  1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0};
    tbl[4]  = '{2'b10, 2'b01, 2'b00, 2'b00, 0,  1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0};
    tbl[5]  = '{2'b10, 2'b01, 2'b01, 2'b00, 0,  1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b01, 2'b00, 0};
    tbl[6]  = '{2'b10, 2'b00, 2'b00, 2'b01, 0,  0, 1, 2'b00, 0, 0, 1, 2'b00, 2'b00, 2'b01, 0};
    tbl[7]  = '{2'b10, 2'b00, 2'b00, 2'b00, 0,  0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1};
    tbl[8]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1,  0, 0, 2'b00, 1, 0, 0, 2'b10, 2'b00, 2'b00, 1};
    tbl[9]  = '{2'b01, 2'b10, 2'b10, 2'b00, 0,  1, 0, 2'b00, 0, 1, 0, 2'b00, 2'b10, 2'b00, 1};
    tbl[10] = '{2'b11, 2'b00, 2'b00, 2'b10, 0,  0, 1, 2'b01, 0, 0, 1, 2'b00, 2'b00, 2'b10, 1};
    tbl[11] = '{2'b11, 2'b00, 2'b00, 2'b00, 0,  0, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0};
    tbl[12] = '{2'b11, 2'b00, 2'b00, 2'b00, 0,  0, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0};

    do_reset();
    @(negedge I_clk);
    chk("reset", dut_vec, '0);
    cyc();

    // ch0 4-beat burst vs ch1 contending, then ch1, then a third contest
    for (int i = 0; i < 13; i++) begin
      awvalid = tbl[i].awv; wvalid = tbl[i].wv; wlast = tbl[i].wl; bready = tbl[i].br;
      axi_awready = tbl[i].awr; axi_wready = tbl[i].wr;
      axi_bvalid = tbl[i].bv; axi_bresp = tbl[i].rsp;
      @(negedge I_clk);
      c = tbl[i].ch ? 1 : 0;
      act = 131'({axi_awvalid, axi_wvalid, axi_bready, awready, wready, bvalid,
                  bresp[1], bresp[0], axi_awaddr, axi_awlen, axi_wdata, axi_wlast});
      exp = 131'({tbl[i].e_awv, tbl[i].e_wv, tbl[i].e_br, tbl[i].e_awr, tbl[i].e_wr, tbl[i].e_bv,
                  (tbl[i].e_bv[1] ? tbl[i].rsp : 2'b00), (tbl[i].e_bv[0] ? tbl[i].rsp : 2'b00),
                  (tbl[i].e_awv ? awaddr[c] : 32'h0), (tbl[i].e_awv ? awlen[c] : 8'h0),
                  (tbl[i].e_wv ? wdata[c] : 64'h0), (tbl[i].e_wv ? tbl[i].wl[c] : 1'b0)});
      chk($sformatf("tbl[%0d]", i), act, exp);
      cyc();
    end

    // ch1 alone, bus awready held low: request must stay on the bus unchanged
    do_reset();
    awaddr[1] = 32'h9000_0040;
    awvalid = 2'b10;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge I_clk);
      chk("aw_stall", 131'({axi_awvalid, axi_awaddr, awready, wready, bvalid, bresp[0]}),
          131'({1'b1, 32'h9000_0040, 2'b00, 2'b00, 2'b00, 2'b00}));
      cyc();
    end
    axi_awready = 1'b1;
    @(negedge I_clk);
    chk("aw_release", 131'({axi_awvalid, awready}), 131'({1'b1, 2'b10}));
    cyc();

    // ch0 single beat, bus answers SLVERR while ch0 holds bready low
    do_reset();
    awlen[0] = 8'd0;
    awvalid = 2'b01;
    cyc();
    axi_awready = 1'b1;
    cyc();
    awvalid = 2'b00; axi_awready = 1'b0;
    wvalid = 2'b01; wlast = 2'b01; axi_wready = 1'b1;
    cyc();
    wvalid = 2'b00; wlast = 2'b00; axi_wready = 1'b0;
    axi_bvalid = 1'b1; axi_bresp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge I_clk);
      chk("b_hold", 131'({bvalid, bresp[0], bresp[1], axi_bready}),
          131'({2'b01, 2'b10, 2'b00, 1'b0}));
      cyc();
    end
    bready = 2'b01;
    @(negedge I_clk);
    chk("b_release", 131'({axi_bready, bvalid, bresp[0]}), 131'({1'b1, 2'b01, 2'b10}));
    cyc();
    zero_inputs();
    @(negedge I_clk);
    chk("b_idle", dut_vec, '0);
    cyc();

    // reset during beat 2 of 4: transaction dropped, ch1 then served
    do_reset();
    awlen[0] = 8'd3;
    awvalid = 2'b01;
    cyc();
    axi_awready = 1'b1;
    cyc();
    awvalid = 2'b00; wvalid = 2'b01; axi_wready = 1'b1;
    cyc();
    I_rst = 1'b1;
    cyc();
    I_rst = 1'b0;
    axi_bvalid = 1'b1; bready = 2'b11;
    @(negedge I_clk);
    chk("rst_mid", dut_vec, '0);
    cyc();
    zero_inputs();
    awaddr[1] = 32'h8000_2000;
    awvalid = 2'b10;
    cyc();
    @(negedge I_clk);
    chk("rst_regrant", 131'({axi_awvalid, axi_awaddr, awready, wready}),
        131'({1'b1, 32'h8000_2000, 2'b00, 2'b00}));
    cyc();

    // randomized traffic against the transaction-level model
    do_reset();
    own = -1; ph = 0; ptr = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom;
        awvalid[k] = r[0];
        wvalid[k]  = r[1];
        wlast[k]   = (r[3:2] == 2'b00);
        bready[k]  = r[4];
        awlen[k]   = r[15:8];
        awsize[k]  = r[18:16];
        awburst[k] = r[20:19];
        wstrb[k]   = r[31:24];
        awaddr[k]  = $urandom;
        wdata[k]   = {$urandom, $urandom};
      end
      r = $urandom;
      axi_awready = r[0];
      axi_wready  = r[1];
      axi_bvalid  = r[2];
      axi_bresp   = r[4:3];
      I_rst       = (r[15:8] == 8'd0);
      @(negedge I_clk);
      chk($sformatf("rand[%0d]", n), dut_vec, model_exp());
      model_step();
      cyc();
    end
    I_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
